// File: rtl/edc_secded_mem.sv
// edc_secded_mem: single-port Wishbone memory storing data plus SECDED check
// bits in one array. It handles byte-lane writes as read-modify-write, writes
// corrected words back on reads, and runs a background scrubber. Errors are
// captured in sticky flags and saturating counters.
// Optional build macro: EDC_INJECT_EN adds i_inj_en / i_inj_mask, which XOR
// the mask into any codeword written while injection is enabled.
module edc_secded_mem #(
    parameter int WB_DWIDTH      = 32,
    parameter int WB_SWIDTH      = 4,
    parameter int MEM_AW         = 12,
    parameter int SCRUB_INTERVAL = 1024,
    parameter int CNT_W          = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [31:0]          i_wb_adr,
    input  logic [WB_SWIDTH-1:0] i_wb_sel,
    input  logic                 i_wb_we,
    input  logic [WB_DWIDTH-1:0] i_wb_dat,
    output logic [WB_DWIDTH-1:0] o_wb_dat,
    input  logic                 i_wb_cyc,
    input  logic                 i_wb_stb,
    output logic                 o_wb_ack,
    output logic                 o_wb_err,
`ifdef EDC_INJECT_EN
    input  logic                 i_inj_en,
    input  logic [WB_DWIDTH+((WB_DWIDTH == 32) ? 7 : (WB_DWIDTH == 64) ? 8 : 9)-1:0] i_inj_mask,
`endif
    output logic [CNT_W-1:0]     o_ce_count,
    output logic [CNT_W-1:0]     o_ue_count,
    output logic [31:0]          o_err_adr,
    output logic                 o_err_irq,
    input  logic                 i_err_clr
);
    localparam int HAM_W   = (WB_DWIDTH == 32) ? 6 : (WB_DWIDTH == 64) ? 7 : 8;
    localparam int ECC_W   = HAM_W + 1;
    localparam int CW      = WB_DWIDTH + ECC_W;
    localparam int NPOS    = WB_DWIDTH + HAM_W;
    localparam int SEL_LSB = $clog2(WB_SWIDTH);
    localparam int ADR_HI  = MEM_AW + SEL_LSB;
    localparam int DEPTH   = 1 << MEM_AW;

    if (!(WB_DWIDTH == 32 || WB_DWIDTH == 64 || WB_DWIDTH == 128)) begin : g_bad_dwidth
        $error("edc_secded_mem: WB_DWIDTH must be 32, 64 or 128");
    end
    if (WB_SWIDTH * 8 != WB_DWIDTH) begin : g_bad_swidth
        $error("edc_secded_mem: WB_SWIDTH must equal WB_DWIDTH/8");
    end

    // Hamming position of data bit idx: data bits fill the non-power-of-two
    // positions 3,5,6,7,9,... so a single-bit syndrome names the bad position.
    function automatic int data_pos(input int idx);
        int q;
        q = 1;
        for (int i = 0; i <= idx; i++) begin
            q++;
            while ((q & (q - 1)) == 0) q++;
        end
        return q;
    endfunction

    typedef enum logic [2:0] {S_IDLE, S_RD, S_RESP, S_RMW_RD, S_RMW_WR, S_SCR_RD, S_SCR_WR} state_t;

    // Codeword layout: {overall parity, Hamming bits, data}
    logic [CW-1:0]        mem [DEPTH];
    logic [CW-1:0]        rd_word, enc_cw, store_cw;
    state_t               state_reg, state_next;
    logic [31:0]          adr_reg, icnt_reg;
    logic [MEM_AW-1:0]    idx_reg, scrub_ptr, rd_idx, mem_widx, req_idx;
    logic [WB_SWIDTH-1:0] sel_reg;
    logic [WB_DWIDTH-1:0] dat_reg, wdata_reg, enc_in, rd_data, cor_data, merged, flip;
    logic [HAM_W-1:0]     enc_term [WB_DWIDTH];
    logic [HAM_W-1:0]     rd_term [WB_DWIDTH];
    logic [HAM_W-1:0]     enc_ham, rd_ham, syn;
    logic                 ce_reg, ue_reg, req, req_oob, scrub_due, accept, mem_we;
    logic                 ack_next, err_next, par_bad, dec_ce, dec_ue, ev_valid;
    logic [CNT_W-1:0]     ce_base, ue_base, ce_next, ue_next;
    logic [31:0]          ev_adr;

    assign req       = i_wb_cyc & i_wb_stb;
    assign req_oob   = |(i_wb_adr >> ADR_HI);
    assign req_idx   = i_wb_adr[ADR_HI-1:SEL_LSB];
    assign scrub_due = (SCRUB_INTERVAL != 0) && (icnt_reg == 32'(SCRUB_INTERVAL - 1));
    assign rd_data   = rd_word[WB_DWIDTH-1:0];

    for (genvar gi = 0; gi < WB_DWIDTH; gi++) begin : g_pos
        localparam logic [HAM_W-1:0] POS_V = HAM_W'(data_pos(gi));
        assign enc_term[gi] = enc_in[gi] ? POS_V : '0;
        assign rd_term[gi]  = rd_data[gi] ? POS_V : '0;
        assign flip[gi]     = par_bad && (syn == POS_V);
    end

    for (genvar gi = 0; gi < WB_SWIDTH; gi++) begin : g_merge
        assign merged[gi*8 +: 8] = sel_reg[gi] ? dat_reg[gi*8 +: 8] : cor_data[gi*8 +: 8];
    end

    // Hamming bits are the XOR of the positions of all set data bits
    always_comb begin
        enc_ham = '0;
        rd_ham  = '0;
        for (int i = 0; i < WB_DWIDTH; i++) begin
            enc_ham ^= enc_term[i];
            rd_ham  ^= rd_term[i];
        end
    end

    assign enc_cw   = {^{enc_ham, enc_in}, enc_ham, enc_in};
    assign syn      = rd_ham ^ rd_word[CW-2:WB_DWIDTH];
    assign par_bad  = ^rd_word;
    assign dec_ce   = par_bad && (syn <= HAM_W'(NPOS));
    assign dec_ue   = (!par_bad && syn != '0) || (par_bad && syn > HAM_W'(NPOS));
    assign cor_data = rd_data ^ flip;

`ifdef EDC_INJECT_EN
    assign store_cw = enc_cw ^ (i_inj_en ? i_inj_mask : '0);
`else
    assign store_cw = enc_cw;
`endif

    // Storage array: one write port, registered read; no write while in reset
    always_ff @(posedge i_clk) begin
        if (mem_we && i_rst_n) mem[mem_widx] <= store_cw;
        rd_word <= mem[rd_idx];
    end

    // FSM state register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) state_reg <= S_IDLE;
        else          state_reg <= state_next;
    end

    // Next state, array port control and bus response selection
    always_comb begin
        state_next = state_reg;
        ack_next   = 1'b0;
        err_next   = 1'b0;
        accept     = 1'b0;
        mem_we     = 1'b0;
        mem_widx   = idx_reg;
        enc_in     = wdata_reg;
        rd_idx     = req_idx;
        case (state_reg)
            S_IDLE: begin
                enc_in = i_wb_dat;
                if (req) begin
                    accept = 1'b1;
                    if (req_oob)        err_next = 1'b1;
                    else if (!i_wb_we)  state_next = S_RD;
                    else if (&i_wb_sel) begin
                        mem_we   = 1'b1;
                        mem_widx = req_idx;
                        ack_next = 1'b1;
                    end
                    else if (~|i_wb_sel) ack_next = 1'b1;
                    else                 state_next = S_RMW_RD;
                end else if (scrub_due) begin
                    state_next = S_SCR_RD;
                end
            end
            S_RD: begin
                ack_next   = ~dec_ue;
                err_next   = dec_ue;
                state_next = S_RESP;
            end
            S_RESP: begin
                mem_we     = ce_reg;
                state_next = S_IDLE;
            end
            S_RMW_RD: state_next = S_RMW_WR;
            S_RMW_WR: begin
                mem_we     = ~ue_reg;
                ack_next   = ~ue_reg;
                err_next   = ue_reg;
                state_next = S_IDLE;
            end
            S_SCR_RD: begin
                rd_idx     = scrub_ptr;
                state_next = S_SCR_WR;
            end
            S_SCR_WR: begin
                enc_in     = cor_data;
                mem_we     = dec_ce;
                mem_widx   = scrub_ptr;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Request capture, read data, RMW merge, scrub pointer and idle interval
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_wb_ack  <= 1'b0;
            o_wb_err  <= 1'b0;
            o_wb_dat  <= '0;
            adr_reg   <= '0;
            idx_reg   <= '0;
            sel_reg   <= '0;
            dat_reg   <= '0;
            wdata_reg <= '0;
            ce_reg    <= 1'b0;
            ue_reg    <= 1'b0;
            scrub_ptr <= '0;
            icnt_reg  <= '0;
        end else begin
            o_wb_ack <= ack_next;
            o_wb_err <= err_next;
            if (accept) begin
                adr_reg <= i_wb_adr;
                idx_reg <= req_idx;
                sel_reg <= i_wb_sel;
                dat_reg <= i_wb_dat;
            end
            if (state_reg == S_RD) begin
                o_wb_dat  <= dec_ue ? rd_data : cor_data;
                wdata_reg <= cor_data;
                ce_reg    <= dec_ce;
            end
            if (state_reg == S_RMW_RD) begin
                wdata_reg <= merged;
                ue_reg    <= dec_ue;
            end
            if (state_reg == S_SCR_WR) scrub_ptr <= scrub_ptr + 1'b1;
            if (state_reg == S_IDLE && !req && SCRUB_INTERVAL != 0 && !scrub_due)
                icnt_reg <= icnt_reg + 32'd1;
            else
                icnt_reg <= '0;
        end
    end

    // Error events come from the single decoder in RD, RMW_RD or SCR_WR
    assign ev_valid = state_reg inside {S_RD, S_RMW_RD, S_SCR_WR};
    assign ev_adr   = (state_reg == S_SCR_WR) ? (32'(scrub_ptr) << SEL_LSB) : adr_reg;

    // Counter update: a clear in the same cycle as an event restarts from zero
    always_comb begin
        ce_base = i_err_clr ? '0 : o_ce_count;
        ue_base = i_err_clr ? '0 : o_ue_count;
        ce_next = (ev_valid && dec_ce && !(&ce_base)) ? ce_base + CNT_W'(1) : ce_base;
        ue_next = (ev_valid && dec_ue && !(&ue_base)) ? ue_base + CNT_W'(1) : ue_base;
    end

    // Sticky capture of the first error address and saturating counters
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_ce_count <= '0;
            o_ue_count <= '0;
            o_err_adr  <= '0;
            o_err_irq  <= 1'b0;
        end else begin
            o_ce_count <= ce_next;
            o_ue_count <= ue_next;
            if (ev_valid && (dec_ce || dec_ue)) begin
                o_err_irq <= 1'b1;
                if (!o_err_irq || i_err_clr) o_err_adr <= ev_adr;
            end else if (i_err_clr) begin
                o_err_irq <= 1'b0;
                o_err_adr <= '0;
            end
        end
    end
endmodule

// File: tb/tb_edc_secded_mem.sv
// Directed bench for edc_secded_mem (32-bit data, 4K words, scrub every 64
// idle cycles). Expected responses go into a scoreboard queue when a request
// is driven and are popped and compared when the slave answers.
module tb_edc_secded_mem;
    localparam int CW = 39;

    typedef struct {
        string       tag;
        logic        err;
        logic [31:0] dat;
        bit          chk_dat;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, we, cyc, stb, ack, err, irq, clr;
    logic [31:0] adr, wdat, rdat, err_adr;
    logic [3:0]  sel;
    logic [15:0] ce_cnt, ue_cnt;
`ifdef EDC_INJECT_EN
    logic          inj_en = 1'b0;
    logic [CW-1:0] inj_mask = '0;
`endif

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    edc_secded_mem #(
        .WB_DWIDTH(32), .WB_SWIDTH(4), .MEM_AW(12), .SCRUB_INTERVAL(64), .CNT_W(16)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_wb_adr(adr), .i_wb_sel(sel), .i_wb_we(we), .i_wb_dat(wdat),
        .o_wb_dat(rdat), .i_wb_cyc(cyc), .i_wb_stb(stb),
        .o_wb_ack(ack), .o_wb_err(err),
`ifdef EDC_INJECT_EN
        .i_inj_en(inj_en), .i_inj_mask(inj_mask),
`endif
        .o_ce_count(ce_cnt), .o_ue_count(ue_cnt),
        .o_err_adr(err_adr), .o_err_irq(irq), .i_err_clr(clr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // One bus transaction; starts and ends just after a falling edge
    task automatic do_req(input string tag, input logic [31:0] a, input logic w,
                          input logic [3:0] s, input logic [31:0] d, input logic exp_err,
                          input logic [31:0] exp_dat, input bit chk_dat, input int exp_lat);
        exp_t        e;
        int          lat;
        logic        got_err;
        logic [31:0] got_dat;
        e.tag = tag; e.err = exp_err; e.dat = exp_dat; e.chk_dat = chk_dat; e.lat = exp_lat;
        sb.push_back(e);
        adr = a; we = w; sel = s; wdat = d; cyc = 1'b1; stb = 1'b1;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!(ack || err) && lat < 20);
        got_err = err;
        got_dat = rdat;
        cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
        e = sb.pop_front();
        $display("txn %-12s adr=%08h we=%0b sel=%h dat=%08h -> err=%0b rdat=%08h lat=%0d",
                 e.tag, a, w, s, d, got_err, got_dat, lat);
        chk({e.tag, "_lat"}, 32'(lat), 32'(e.lat));
        chk({e.tag, "_err"}, {31'b0, got_err}, {31'b0, e.err});
        if (e.chk_dat) chk({e.tag, "_dat"}, got_dat, e.dat);
        @(negedge clk);
        chk({e.tag, "_pulse"}, {30'b0, ack, err}, 32'd0);
    endtask

    // Full write whose stored codeword has mask XORed in
    task automatic write_corrupt(input string tag, input logic [31:0] a,
                                 input logic [31:0] d, input logic [CW-1:0] mask);
`ifdef EDC_INJECT_EN
        inj_en = 1'b1; inj_mask = mask;
        do_req(tag, a, 1'b1, 4'hF, d, 1'b0, 32'h0, 1'b0, 1);
        inj_en = 1'b0; inj_mask = '0;
`else
        do_req(tag, a, 1'b1, 4'hF, d, 1'b0, 32'h0, 1'b0, 1);
        dut.mem[a[13:2]] = dut.mem[a[13:2]] ^ mask;
`endif
    endtask

    task automatic chk_status(input string tag, input logic [15:0] ce, input logic [15:0] ue,
                              input logic [31:0] ea, input logic ir);
        chk({tag, "_ce"}, {16'b0, ce_cnt}, {16'b0, ce});
        chk({tag, "_ue"}, {16'b0, ue_cnt}, {16'b0, ue});
        chk({tag, "_eadr"}, err_adr, ea);
        chk({tag, "_irq"}, {31'b0, irq}, {31'b0, ir});
    endtask

    initial begin
        rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
        adr = '0; wdat = '0; clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ack", {30'b0, ack, err}, 32'd0);
        chk("rst_dat", rdat, 32'd0);
        chk_status("rst", 16'd0, 16'd0, 32'd0, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Scrubber: single-bit errors in words 0 and 1, then let it run
        write_corrupt("scr_w0", 32'h0, 32'h12345678, 39'(1) << 5);
        write_corrupt("scr_w1", 32'h4, 32'hCAFEF00D, 39'(1) << 1);
        repeat (100) @(negedge clk);
        chk_status("scr_first", 16'd1, 16'd0, 32'h0, 1'b1);
        repeat (40) @(negedge clk);
        chk_status("scr_second", 16'd2, 16'd0, 32'h0, 1'b1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        chk_status("clr", 16'd0, 16'd0, 32'h0, 1'b0);
        do_req("scr_rd1", 32'h4, 1'b0, 4'hF, 32'h0, 1'b0, 32'hCAFEF00D, 1'b1, 2);
        do_req("scr_rd0", 32'h0, 1'b0, 4'hF, 32'h0, 1'b0, 32'h12345678, 1'b1, 2);
        chk_status("scr_clean", 16'd0, 16'd0, 32'h0, 1'b0);

        // Plain full write and read
        do_req("wr_full", 32'h10, 1'b1, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0, 1);
        do_req("rd_full", 32'h10, 1'b0, 4'hF, 32'h0, 1'b0, 32'hDEADBEEF, 1'b1, 2);
        chk_status("basic", 16'd0, 16'd0, 32'h0, 1'b0);

        // Partial write merges one lane
        do_req("wr_base", 32'h20, 1'b1, 4'hF, 32'h11223344, 1'b0, 32'h0, 1'b0, 1);
        do_req("wr_part", 32'h20, 1'b1, 4'b0010, 32'h0000AA00, 1'b0, 32'h0, 1'b0, 3);
        do_req("rd_part", 32'h20, 1'b0, 4'hF, 32'h0, 1'b0, 32'h1122AA44, 1'b1, 2);

        // Correctable read error, then write-back makes the re-read clean
        write_corrupt("ce_wr", 32'h40, 32'h0, 39'(1) << 5);
        do_req("ce_rd", 32'h40, 1'b0, 4'hF, 32'h0, 1'b0, 32'h0, 1'b1, 2);
        chk_status("ce", 16'd1, 16'd0, 32'h40, 1'b1);
        do_req("ce_rerd", 32'h40, 1'b0, 4'hF, 32'h0, 1'b0, 32'h0, 1'b1, 2);
        chk("ce_rerd_cnt", {16'b0, ce_cnt}, 32'd1);

        // Uncorrectable: read errors with raw data, partial write refused
        write_corrupt("ue_wr", 32'h44, 32'h0, (39'(1) << 3) | (39'(1) << 9));
        do_req("ue_rd", 32'h44, 1'b0, 4'hF, 32'h0, 1'b1, 32'h00000208, 1'b1, 2);
        chk("ue_cnt1", {16'b0, ue_cnt}, 32'd1);
        do_req("ue_part", 32'h44, 1'b1, 4'b0001, 32'h000000FF, 1'b1, 32'h0, 1'b0, 3);
        do_req("ue_rerd", 32'h44, 1'b0, 4'hF, 32'h0, 1'b1, 32'h00000208, 1'b1, 2);
        chk_status("ue", 16'd1, 16'd3, 32'h40, 1'b1);

        // Partial write over a correctable word merges corrected data
        write_corrupt("cem_wr", 32'h48, 32'hA5A5A5A5, 39'(1) << 2);
        do_req("cem_part", 32'h48, 1'b1, 4'b1000, 32'h3C000000, 1'b0, 32'h0, 1'b0, 3);
        do_req("cem_rd", 32'h48, 1'b0, 4'hF, 32'h0, 1'b0, 32'h3CA5A5A5, 1'b1, 2);
        chk("cem_cnt", {16'b0, ce_cnt}, 32'd2);

        // Errors confined to a Hamming bit and to the overall parity bit
        write_corrupt("hb_wr", 32'h4C, 32'h0F0F0F0F, 39'(1) << 32);
        do_req("hb_rd", 32'h4C, 1'b0, 4'hF, 32'h0, 1'b0, 32'h0F0F0F0F, 1'b1, 2);
        write_corrupt("pb_wr", 32'h50, 32'h76543210, 39'(1) << 38);
        do_req("pb_rd", 32'h50, 1'b0, 4'hF, 32'h0, 1'b0, 32'h76543210, 1'b1, 2);
        chk_status("chkbits", 16'd4, 16'd3, 32'h40, 1'b1);

        // Empty byte select and out-of-range addresses
        do_req("wr_sel0", 32'h10, 1'b1, 4'h0, 32'h01234567, 1'b0, 32'h0, 1'b0, 1);
        do_req("rd_sel0", 32'h10, 1'b0, 4'hF, 32'h0, 1'b0, 32'hDEADBEEF, 1'b1, 2);
        do_req("rd_oob", 32'h4000, 1'b0, 4'hF, 32'h0, 1'b1, 32'h0, 1'b0, 1);
        do_req("wr_oob", 32'h8000_0010, 1'b1, 4'hF, 32'h1, 1'b1, 32'h0, 1'b0, 1);
        do_req("rd_after_oob", 32'h10, 1'b0, 4'hF, 32'h0, 1'b0, 32'hDEADBEEF, 1'b1, 2);
        chk_status("oob", 16'd4, 16'd3, 32'h40, 1'b1);

        // Reset during the RMW write cycle drops the write and the ack
        adr = 32'h10; we = 1'b1; sel = 4'b0001; wdat = 32'h000000FF; cyc = 1'b1; stb = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
        @(negedge clk);
        $display("txn %-12s adr=%08h reset during RMW_WR -> ack=%0b err=%0b", "rst_mid", 32'h10, ack, err);
        chk("rst_mid_resp", {30'b0, ack, err}, 32'd0);
        chk_status("rst_mid", 16'd0, 16'd0, 32'h0, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        do_req("rd_rst_mid", 32'h10, 1'b0, 4'hF, 32'h0, 1'b0, 32'hDEADBEEF, 1'b1, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
